snitch_narrow_in_initiator: RTL and testbench

// - Single-outstanding AXI4 initiator driving the cluster's narrow slave port (narrow_in_req/resp).
// - Counterpart of the simulation memory responder on narrow_out.
// - Turns a simple valid/ready command stream into single-beat AXI reads or writes.
// - Returns read data and response codes on a response stream.
// - Used by testbenches and host-side bridges to preload TCDM, poke peripherals and raise wake-ups.

---
 rtl/snitch_narrow_in_initiator.sv | 256 +++++++++++++++++++++++++
 tb/tb_snitch_narrow_in_initiator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_narrow_in_initiator.sv
// Single-outstanding AXI4 initiator: valid/ready command stream -> one single-beat read or write.
// Optional watchdog enabled by SNITCH_NARROW_IN_INITIATOR_TIMEOUT_EN.
package snitch_narrow_in_pkg;
  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;
  typedef struct packed {
    logic [1:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;
  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ar_chan_t;
  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } narrow_in_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } narrow_in_resp_t;
endpackage

module snitch_narrow_in_initiator #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned IdWidth       = 2,
  parameter int unsigned UserWidth     = 1,
  parameter int unsigned TxnId         = 0,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type req_t = snitch_narrow_in_pkg::narrow_in_req_t,
  parameter type rsp_t = snitch_narrow_in_pkg::narrow_in_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_data_i,
  input  logic [DataWidth/8-1:0] cmd_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_data_o,
  output logic [1:0]             rsp_resp_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output req_t                   axi_req_o,
  input  rsp_t                   axi_rsp_i
);
  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // WR     | AW and W outstanding, each drops on its own handshake
  // WR_B   | waiting for write response
  // RD_AR  | AR outstanding
  // RD_R   | waiting for read data
  // RSP    | response held on rsp_* until consumed
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  localparam logic [2:0] AxSize = 3'($clog2(DataWidth / 8));

  state_t                 state;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] strb;
  logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic rsp_valid, cmd_ready, busy;
  logic [DataWidth-1:0] rsp_data;
  logic [1:0]           rsp_resp;
  logic aw_pending, w_pending;

  assign aw_pending = aw_valid && !axi_rsp_i.aw_ready;
  assign w_pending  = w_valid && !axi_rsp_i.w_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      strb      <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      ar_valid  <= 1'b0;
      b_ready   <= 1'b0;
      r_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= 2'b00;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i && cmd_ready) begin
          addr      <= cmd_addr_i;
          wdata     <= cmd_data_i;
          strb      <= cmd_strb_i;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          if (cmd_write_i) begin
            state    <= WR;
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
          end else begin
            state    <= RD_AR;
            ar_valid <= 1'b1;
          end
        end
        WR: begin
          if (aw_valid && axi_rsp_i.aw_ready) aw_valid <= 1'b0;
          if (w_valid && axi_rsp_i.w_ready) w_valid <= 1'b0;
          if (!aw_pending && !w_pending) begin
            state   <= WR_B;
            b_ready <= 1'b1;
          end
        end
        WR_B: if (axi_rsp_i.b_valid) begin
          b_ready   <= 1'b0;
          rsp_data  <= '0;
          rsp_resp  <= axi_rsp_i.b.resp;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RD_AR: if (axi_rsp_i.ar_ready) begin
          ar_valid <= 1'b0;
          r_ready  <= 1'b1;
          state    <= RD_R;
        end
        RD_R: if (axi_rsp_i.r_valid) begin
          r_ready   <= 1'b0;
          rsp_data  <= axi_rsp_i.r.data;
          rsp_resp  <= axi_rsp_i.r.resp;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready_i) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = IdWidth'(TxnId);
    axi_req_o.aw.addr   = addr;
    axi_req_o.aw.size   = AxSize;
    axi_req_o.aw.burst  = 2'b01;
    axi_req_o.aw.user   = UserWidth'(0);
    axi_req_o.aw_valid  = aw_valid;
    axi_req_o.w.data    = wdata;
    axi_req_o.w.strb    = strb;
    axi_req_o.w.last    = 1'b1;
    axi_req_o.w_valid   = w_valid;
    axi_req_o.b_ready   = b_ready;
    axi_req_o.ar.id     = IdWidth'(TxnId);
    axi_req_o.ar.addr   = addr;
    axi_req_o.ar.size   = AxSize;
    axi_req_o.ar.burst  = 2'b01;
    axi_req_o.ar_valid  = ar_valid;
    axi_req_o.r_ready   = r_ready;
  end

  assign cmd_ready_o = cmd_ready;
  assign rsp_valid_o = rsp_valid;
  assign rsp_data_o  = rsp_data;
  assign rsp_resp_o  = rsp_resp;
  assign busy_o      = busy;

  // IDs, user bits and r.last are ignored: only one transaction is ever in flight.
  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id,
                        axi_rsp_i.r.last, axi_rsp_i.r.user};

`ifdef SNITCH_NARROW_IN_INITIATOR_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] Limit = CntWidth'(TimeoutCycles);

  state_t              state_q;
  logic [CntWidth-1:0] cnt, cnt_next;
  logic                waiting, timeout;

  assign waiting  = state inside {WR, WR_B, RD_AR, RD_R};
  // Saturate so a long stall cannot wrap the count.
  assign cnt_next = (state != state_q) ? CntWidth'(1) :
                    (cnt == Limit) ? cnt : cnt + CntWidth'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state;
      cnt     <= waiting ? cnt_next : '0;
      if (waiting && cnt_next == Limit) timeout <= 1'b1;
    end
  end

  assign timeout_o = timeout;
`else
  logic unused_cfg;
  assign unused_cfg = (TimeoutCycles != 0);
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_snitch_narrow_in_initiator.sv
// Directed bench for snitch_narrow_in_initiator with a small AXI slave model on the request port.
module tb_snitch_narrow_in_initiator;
  import snitch_narrow_in_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [47:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [7:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        busy, timeout;
  narrow_in_req_t  axi_req;
  narrow_in_resp_t axi_rsp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snitch_narrow_in_initiator #(.TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_resp_o(rsp_resp), .busy_o(busy), .timeout_o(timeout),
    .axi_req_o(axi_req), .axi_rsp_i(axi_rsp)
  );

  // slave model: ready knobs, B/R gated by enables, 4-word memory committed on B
  logic        aw_rdy_en, w_rdy_en, ar_rdy_en, b_en, r_en;
  logic [1:0]  r_resp_cfg;
  logic        got_aw, got_w, got_ar;
  logic [47:0] s_awaddr, s_araddr;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic [63:0] mem [4];
  int          b_cnt = 0;

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  always_comb begin
    axi_rsp          = '0;
    axi_rsp.aw_ready = aw_rdy_en;
    axi_rsp.w_ready  = w_rdy_en;
    axi_rsp.ar_ready = ar_rdy_en;
    axi_rsp.b_valid  = got_aw && got_w && b_en;
    axi_rsp.r_valid  = got_ar && r_en;
    axi_rsp.r.data   = mem[s_araddr[4:3]];
    axi_rsp.r.resp   = r_resp_cfg;
    axi_rsp.r.last   = 1'b1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      got_ar <= 1'b0;
    end else begin
      if (axi_req.aw_valid && axi_rsp.aw_ready) begin
        got_aw   <= 1'b1;
        s_awaddr <= axi_req.aw.addr;
      end
      if (axi_req.w_valid && axi_rsp.w_ready) begin
        got_w   <= 1'b1;
        s_wdata <= axi_req.w.data;
        s_wstrb <= axi_req.w.strb;
      end
      if (axi_rsp.b_valid && axi_req.b_ready) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        b_cnt  <= b_cnt + 1;
        mem[s_awaddr[4:3]] <= merge(mem[s_awaddr[4:3]], s_wdata, s_wstrb);
      end
      if (axi_req.ar_valid && axi_rsp.ar_ready) begin
        got_ar   <= 1'b1;
        s_araddr <= axi_req.ar.addr;
      end
      if (axi_rsp.r_valid && axi_req.r_ready) got_ar <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [47:0] a, input logic [63:0] d,
                       input logic [7:0] s);
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    chk("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int i = 0;
    while (rsp_valid !== 1'b1 && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(rsp_valid), 64'd1);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk(tag, {62'd0, rsp_valid, cmd_ready}, 64'b01);
  endtask

  initial begin
    int b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_strb = '0; rsp_ready = 1'b0;
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1; ar_rdy_en = 1'b1; b_en = 1'b1; r_en = 1'b1;
    r_resp_cfg = 2'b00;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_valids", {58'd0, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                       axi_req.b_ready, axi_req.r_ready, rsp_valid}, 64'd0);
    chk("rst_cmd_ready_busy", {62'd0, cmd_ready, busy}, 64'b10);
    chk("rst_rsp", {rsp_data[61:0], rsp_resp}, 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);

    // zero-wait write
    issue(1'b1, 48'h1000_0000, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    chk("wr_c1_valids", {62'd0, axi_req.aw_valid, axi_req.w_valid}, 64'b11);
    chk("wr_c1_addr", 64'(axi_req.aw.addr), 64'h1000_0000);
    chk("wr_c1_data", axi_req.w.data, 64'hDEADBEEF_CAFEF00D);
    chk("wr_c1_strb_last", {55'd0, axi_req.w.strb, axi_req.w.last}, {55'd0, 8'hFF, 1'b1});
    chk("wr_c1_aw_fields", {49'd0, axi_req.aw.id, axi_req.aw.len, axi_req.aw.size,
                            axi_req.aw.burst}, {49'd0, 2'd0, 8'd0, 3'd3, 2'b01});
    chk("wr_c1_ready_busy", {62'd0, cmd_ready, busy}, 64'b01);
    @(negedge clk);
    chk("wr_c2", {60'd0, axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, rsp_valid},
        64'b0010);
    @(negedge clk);
    chk("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_c3_resp", 64'(rsp_resp), 64'd0);
    chk("wr_c3_data", rsp_data, 64'd0);
    consume("wr_consume");

    // read back
    issue(1'b0, 48'h1000_0000, 64'd0, 8'd0);
    chk("rd_c1_ar", {62'd0, axi_req.ar_valid, axi_req.aw_valid}, 64'b10);
    chk("rd_c1_fields", {11'd0, axi_req.ar.addr, axi_req.ar.len[4:0]}, {11'd0, 48'h1000_0000, 5'd0});
    chk("rd_c1_size", 64'(axi_req.ar.size), 64'd3);
    @(negedge clk);
    chk("rd_c2", {62'd0, axi_req.ar_valid, axi_req.r_ready}, 64'b01);
    @(negedge clk);
    chk("rd_c3_valid", 64'(rsp_valid), 64'd1);
    chk("rd_c3_data", rsp_data, 64'hDEADBEEF_CAFEF00D);
    chk("rd_c3_resp", 64'(rsp_resp), 64'd0);
    consume("rd_consume");

    // W ready 5 cycles after AW handshake
    w_rdy_en = 1'b0;
    b0 = b_cnt;
    issue(1'b1, 48'h1000_0008, 64'h11223344_55667788, 8'h0F);
    chk("wd_c1", {62'd0, axi_req.aw_valid, axi_req.w_valid}, 64'b11);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk("wd_hold", {62'd0, axi_req.aw_valid, axi_req.w_valid}, 64'b01);
    end
    w_rdy_en = 1'b1;
    wait_rsp("wd_rsp");
    chk("wd_resp", 64'(rsp_resp), 64'd0);
    chk("wd_b_count", 64'(b_cnt - b0), 64'd1);
    consume("wd_consume");
    repeat (3) @(negedge clk);
    chk("wd_b_count_after", 64'(b_cnt - b0), 64'd1);
    issue(1'b0, 48'h1000_0008, 64'd0, 8'd0);
    wait_rsp("wd_rd_rsp");
    chk("wd_rd_data", rsp_data, 64'h00000000_55667788);
    consume("wd_rd_consume");

    // DECERR read, response back-pressured
    r_resp_cfg = 2'b11;
    issue(1'b0, 48'h1000_0000, 64'd0, 8'd0);
    wait_rsp("dec_rsp");
    cmd_write = 1'b1;
    cmd_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("dec_hold_resp", {61'd0, rsp_valid, rsp_resp}, 64'b111);
      chk("dec_hold_data", rsp_data, 64'hDEADBEEF_CAFEF00D);
      chk("dec_hold_cmd", {62'd0, cmd_ready, axi_req.aw_valid}, 64'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    consume("dec_consume");
    r_resp_cfg = 2'b00;

    // reset while waiting for B
    b_en = 1'b0;
    issue(1'b1, 48'h1000_0010, 64'hA5A5A5A5_A5A5A5A5, 8'hFF);
    @(negedge clk);
    chk("rstb_in_wr_b", 64'(axi_req.b_ready), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstb_valids", {58'd0, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                        axi_req.b_ready, axi_req.r_ready, rsp_valid}, 64'd0);
    chk("rstb_cmd_ready", {62'd0, cmd_ready, busy}, 64'b10);
    @(negedge clk);
    rst = 1'b0;
    b_en = 1'b1;
    @(negedge clk);
    issue(1'b1, 48'h1000_0010, 64'h01234567_89ABCDEF, 8'hFF);
    wait_rsp("rstb_wr_rsp");
    chk("rstb_wr_resp", 64'(rsp_resp), 64'd0);
    consume("rstb_wr_consume");
    issue(1'b0, 48'h1000_0010, 64'd0, 8'd0);
    wait_rsp("rstb_rd_rsp");
    chk("rstb_rd_data", rsp_data, 64'h01234567_89ABCDEF);
    consume("rstb_rd_consume");

    // B withheld 20 cycles: watchdog fires only when the feature is built in
    b_en = 1'b0;
    issue(1'b1, 48'h1000_0018, 64'h0, 8'hFF);
    repeat (8) @(negedge clk);
    chk("to_early", 64'(timeout), 64'd0);
    repeat (12) @(negedge clk);
`ifdef SNITCH_NARROW_IN_INITIATOR_TIMEOUT_EN
    chk("to_set", 64'(timeout), 64'd1);
`else
    chk("to_tied", 64'(timeout), 64'd0);
`endif
    chk("to_no_rsp", 64'(rsp_valid), 64'd0);
    b_en = 1'b1;
    wait_rsp("to_rsp");
    consume("to_consume");
`ifdef SNITCH_NARROW_IN_INITIATOR_TIMEOUT_EN
    chk("to_sticky", 64'(timeout), 64'd1);
`else
    chk("to_sticky", 64'(timeout), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
